axis_pair_aligner: RTL

- Upstream stage of the two-stream comparator.
- Accepts two independent AXI4-Stream inputs with arbitrary relative timing. Buffers each input in its own FIFO and releases beats in lockstep, so both outputs are valid in the same cycle for every beat.
- The comparator always samples both inputs together, so unmatched beats must never reach it. This block guarantees that.
- Also reports pair count and worst-case inter-stream skew for debug.

---
 rtl/axis_pair_aligner.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/axis_pair_aligner.sv
// ---------------------------------------------------------------------------
// axis_pair_aligner
//
// Purpose:
//   Front end of the two-stream comparator. Each of two independent
//   AXI4-Stream inputs is buffered in its own FIFO. Beats are released in
//   lockstep: both outputs are valid in the same cycle, and both lanes are
//   popped together. An unmatched beat never appears on the output. The
//   block also reports occupancy, the number of released pairs and the
//   peak occupancy difference between the lanes, for debug.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   in1_* / in2_*          lane 1 / lane 2 input streams (data, valid, ready)
//   out1_* / out2_*        lane 1 / lane 2 aligned output streams
//   level1, level2         per-lane FIFO occupancy (0..DEPTH)
//   pair_count             number of pairs released, wraps silently
//   max_skew               sticky peak of |level1 - level2|
//
// Handshake: a beat transfers on the rising clk edge where valid and ready
// are both 1. A source holds valid and data stable until that edge. Here
// out1_valid/out2_valid depend only on registered state, so they stay high
// and the head data stays stable until the pair is popped. in*_ready also
// depends only on registered state: there is no combinational path from
// out*_ready to in*_ready.
// ---------------------------------------------------------------------------
module axis_pair_aligner #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 8,
  localparam int LW         = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  resetn,

  input  logic [DATA_WIDTH-1:0] in1_data,
  input  logic                  in1_valid,
  output logic                  in1_ready,

  input  logic [DATA_WIDTH-1:0] in2_data,
  input  logic                  in2_valid,
  output logic                  in2_ready,

  output logic [DATA_WIDTH-1:0] out1_data,
  output logic                  out1_valid,
  input  logic                  out1_ready,

  output logic [DATA_WIDTH-1:0] out2_data,
  output logic                  out2_valid,
  input  logic                  out2_ready,

  output logic [LW-1:0]         level1,
  output logic [LW-1:0]         level2,
  output logic [31:0]           pair_count,
  output logic [LW-1:0]         max_skew
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  // Storage and pointers. Pointers are AW bits and wrap modulo DEPTH; the
  // level is one bit wider so that full and empty are distinct.
  logic [DATA_WIDTH-1:0] mem1 [DEPTH];
  logic [DATA_WIDTH-1:0] mem2 [DEPTH];
  logic [AW-1:0]         wr_ptr1, rd_ptr1;
  logic [AW-1:0]         wr_ptr2, rd_ptr2;

  // Held low by reset and set on the first edge after release, so that
  // in*_ready stays 0 throughout reset and rises on that first edge.
  logic                  ready_en;

  logic                  push1, push2, pop, pair_avail;
  logic [LW-1:0]         level1_next, level2_next, skew_next;

  // ---------------------------------------------------------------- input
  assign in1_ready = ready_en && (level1 != FULL_LEVEL);
  assign in2_ready = ready_en && (level2 != FULL_LEVEL);
  assign push1     = in1_valid && in1_ready;
  assign push2     = in2_valid && in2_ready;

  // --------------------------------------------------------------- output
  // Both lanes must hold a beat before anything is offered; both lanes are
  // popped in the same cycle, so lanes never drift apart in beat count.
  assign pair_avail = (level1 != '0) && (level2 != '0);
  assign out1_valid = pair_avail;
  assign out2_valid = pair_avail;
  assign out1_data  = mem1[rd_ptr1];
  assign out2_data  = mem2[rd_ptr2];
  assign pop        = pair_avail && out1_ready && out2_ready;

  // ------------------------------------------------------ next-state levels
  always_comb begin
    level1_next = level1;
    level2_next = level2;
    if (push1 && !pop) begin
      level1_next = level1 + 1'b1;
    end else if (!push1 && pop) begin
      level1_next = level1 - 1'b1;
    end
    if (push2 && !pop) begin
      level2_next = level2 + 1'b1;
    end else if (!push2 && pop) begin
      level2_next = level2 - 1'b1;
    end
    // Skew is measured on the levels the registers are about to take.
    if (level1_next >= level2_next) begin
      skew_next = level1_next - level2_next;
    end else begin
      skew_next = level2_next - level1_next;
    end
  end

  // ------------------------------------------------------- control state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_en   <= 1'b0;
      wr_ptr1    <= '0;
      rd_ptr1    <= '0;
      wr_ptr2    <= '0;
      rd_ptr2    <= '0;
      level1     <= '0;
      level2     <= '0;
      pair_count <= '0;
      max_skew   <= '0;
    end else begin
      ready_en <= 1'b1;
      if (push1) begin
        wr_ptr1 <= wr_ptr1 + 1'b1;
      end
      if (push2) begin
        wr_ptr2 <= wr_ptr2 + 1'b1;
      end
      if (pop) begin
        rd_ptr1    <= rd_ptr1 + 1'b1;
        rd_ptr2    <= rd_ptr2 + 1'b1;
        pair_count <= pair_count + 32'd1;
      end
      level1 <= level1_next;
      level2 <= level2_next;
      if (skew_next > max_skew) begin
        max_skew <= skew_next;
      end
    end
  end

  // ---------------------------------------------------------- data storage
  // Payload RAM is not reset: stale entries are unreachable because the
  // levels and pointers are cleared.
  always_ff @(posedge clk) begin
    if (push1) begin
      mem1[wr_ptr1] <= in1_data;
    end
    if (push2) begin
      mem2[wr_ptr2] <= in2_data;
    end
  end

endmodule
